// File: rtl/mc_control_fsm_if.sv
// Memory handshake between the control sequencer and the unified
// instruction/data memory. The sequencer is the master.
interface mc_control_fsm_if;
  logic mem_req;
  logic mem_write;
  logic mem_ready;

  modport master (
    output mem_req,
    output mem_write,
    input  mem_ready
  );

  modport slave (
    input  mem_req,
    input  mem_write,
    output mem_ready
  );
endinterface

// File: rtl/mc_control_fsm.sv
// Multi-cycle control sequencer for an RV32I subset core (lw, sw, R-type,
// I-type ALU, beq/bne). Drives the shared-datapath selects each cycle and
// stalls on the memory ready handshake.
// Optional feature: define MC_CTRL_JAL_EN to add the JAL state (opcode 1101111).
module mc_control_fsm (
  input  logic             clk,
  input  logic             rst_n,
  mc_control_fsm_if.master mem,
  input  logic [6:0]       opcode,
  input  logic [2:0]       funct3,
  input  logic             funct7b5,
  input  logic             zero,
  output logic             adr_src,
  output logic             ir_write,
  output logic             pc_write,
  output logic             reg_write,
  output logic [1:0]       imm_src,
  output logic [1:0]       alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [2:0]       alu_control,
  output logic [1:0]       result_src,
  output logic             illegal_instr
);

  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpRType  = 7'b0110011;
  localparam logic [6:0] OpIType  = 7'b0010011;
  localparam logic [6:0] OpBranch = 7'b1100011;
`ifdef MC_CTRL_JAL_EN
  localparam logic [6:0] OpJal    = 7'b1101111;
`endif

  localparam logic [2:0] AluAdd = 3'b000;
  localparam logic [2:0] AluSub = 3'b001;
  localparam logic [2:0] AluAnd = 3'b010;
  localparam logic [2:0] AluOr  = 3'b011;
  localparam logic [2:0] AluSlt = 3'b101;

  typedef enum logic [3:0] {
    StIdle,
    StFetch,
    StDecode,
    StMemAdr,
    StMemRead,
    StMemWb,
    StMemWrite,
    StExecR,
    StExecI,
    StAluWb,
    StBranch
`ifdef MC_CTRL_JAL_EN
    , StJal
`endif
  } state_e;

  state_e     state_q, state_d;
  logic       mem_req_c;
  logic       mem_write_c;
  logic [2:0] alu_dec;

  assign mem.mem_req   = mem_req_c;
  assign mem.mem_write = mem_write_c;

  // State register; reset abandons any instruction in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // ALU operation for the execute states, decoded from funct3.
  always_comb begin
    alu_dec = AluAdd;
    case (funct3)
      3'b000:  alu_dec = (opcode == OpRType && funct7b5) ? AluSub : AluAdd;
      3'b010:  alu_dec = AluSlt;
      3'b110:  alu_dec = AluOr;
      3'b111:  alu_dec = AluAnd;
      default: alu_dec = AluAdd;
    endcase
  end

  // Next-state and per-state datapath controls.
  always_comb begin
    state_d       = state_q;
    mem_req_c     = 1'b0;
    mem_write_c   = 1'b0;
    adr_src       = 1'b0;
    ir_write      = 1'b0;
    pc_write      = 1'b0;
    reg_write     = 1'b0;
    imm_src       = 2'b00;
    alu_src_a     = 2'b00;
    alu_src_b     = 2'b00;
    alu_control   = AluAdd;
    result_src    = 2'b00;
    illegal_instr = 1'b0;
    case (state_q)
      StIdle: state_d = StFetch;
      StFetch: begin
        mem_req_c  = 1'b1;
        alu_src_b  = 2'b10;
        result_src = 2'b10;
        if (mem.mem_ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          state_d  = StDecode;
        end
      end
      StDecode: begin
        // Branch (or jump) target lands in the ALU-out register here.
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
        imm_src   = 2'b10;
`ifdef MC_CTRL_JAL_EN
        if (opcode == OpJal) imm_src = 2'b11;
`endif
        case (opcode)
          OpLoad, OpStore: state_d = StMemAdr;
          OpRType:         state_d = StExecR;
          OpIType:         state_d = StExecI;
          OpBranch:        state_d = StBranch;
`ifdef MC_CTRL_JAL_EN
          OpJal:           state_d = StJal;
`endif
          default: begin
            illegal_instr = 1'b1;
            state_d       = StFetch;
          end
        endcase
      end
      StMemAdr: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        imm_src   = (opcode == OpStore) ? 2'b01 : 2'b00;
        state_d   = (opcode == OpStore) ? StMemWrite : StMemRead;
      end
      StMemRead: begin
        mem_req_c = 1'b1;
        adr_src   = 1'b1;
        if (mem.mem_ready) state_d = StMemWb;
      end
      StMemWb: begin
        result_src = 2'b01;
        reg_write  = 1'b1;
        state_d    = StFetch;
      end
      StMemWrite: begin
        mem_req_c   = 1'b1;
        mem_write_c = 1'b1;
        adr_src     = 1'b1;
        if (mem.mem_ready) state_d = StFetch;
      end
      StExecR: begin
        alu_src_a   = 2'b10;
        alu_control = alu_dec;
        state_d     = StAluWb;
      end
      StExecI: begin
        alu_src_a   = 2'b10;
        alu_src_b   = 2'b01;
        alu_control = alu_dec;
        state_d     = StAluWb;
      end
      StAluWb: begin
        reg_write = 1'b1;
        state_d   = StFetch;
      end
      StBranch: begin
        alu_src_a   = 2'b10;
        alu_control = AluSub;
        case (funct3)
          3'b000:  pc_write = zero;
          3'b001:  pc_write = ~zero;
          default: pc_write = 1'b0;
        endcase
        state_d = StFetch;
      end
`ifdef MC_CTRL_JAL_EN
      StJal: begin
        // PC takes the precomputed target; the ALU forms old PC + 4 for the link.
        alu_src_a = 2'b01;
        alu_src_b = 2'b10;
        pc_write  = 1'b1;
        state_d   = StAluWb;
      end
`endif
      default: state_d = StIdle;
    endcase
  end

endmodule

// File: tb/tb_mc_control_fsm.sv
// Scoreboard bench for mc_control_fsm: stimulus pushes the expected control
// word for every cycle, a negedge monitor pops and compares.
module tb_mc_control_fsm;

  typedef struct packed {
    logic       mem_req;
    logic       mem_write;
    logic       adr_src;
    logic       ir_write;
    logic       pc_write;
    logic       reg_write;
    logic [1:0] imm_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_control;
    logic [1:0] result_src;
    logic       illegal_instr;
  } ctl_t;

`ifdef MC_CTRL_JAL_EN
  localparam bit JalEn = 1'b1;
`else
  localparam bit JalEn = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [6:0] opcode = '0;
  logic [2:0] funct3 = '0;
  logic       funct7b5 = 1'b0;
  logic       zero = 1'b0;
  logic       adr_src, ir_write, pc_write, reg_write, illegal_instr;
  logic [1:0] imm_src, alu_src_a, alu_src_b, result_src;
  logic [2:0] alu_control;
  ctl_t       got;

  mc_control_fsm_if mem_if ();

  mc_control_fsm dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .mem           (mem_if),
    .opcode        (opcode),
    .funct3        (funct3),
    .funct7b5      (funct7b5),
    .zero          (zero),
    .adr_src       (adr_src),
    .ir_write      (ir_write),
    .pc_write      (pc_write),
    .reg_write     (reg_write),
    .imm_src       (imm_src),
    .alu_src_a     (alu_src_a),
    .alu_src_b     (alu_src_b),
    .alu_control   (alu_control),
    .result_src    (result_src),
    .illegal_instr (illegal_instr)
  );

  always #5 clk = ~clk;

  assign got = {mem_if.mem_req, mem_if.mem_write, adr_src, ir_write, pc_write, reg_write,
                imm_src, alu_src_a, alu_src_b, alu_control, result_src, illegal_instr};

  ctl_t  exp_q[$];
  string name_q[$];
  string steps[$];
  int    vectors = 0;
  int    miscompares = 0;

  // Monitor: one expected control word per cycle, checked mid-cycle.
  ctl_t  mon_e;
  string mon_n;
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      mon_n = name_q.pop_front();
      vectors++;
      if (got !== mon_e) begin
        miscompares++;
        $display("FAIL %s got=%h want=%h", mon_n, got, mon_e);
      end
    end
  end

  // ---------------- reference model ----------------
  function automatic logic [2:0] alu_ref(input logic [2:0] f3, input logic is_r,
                                         input logic f7);
    if (f3 == 3'b000) return (is_r && f7) ? 3'b001 : 3'b000;
    if (f3 == 3'b010) return 3'b101;
    if (f3 == 3'b110) return 3'b011;
    if (f3 == 3'b111) return 3'b010;
    return 3'b000;
  endfunction

  function automatic string op_class(input logic [6:0] op);
    if (op == 7'b0000011) return "load";
    if (op == 7'b0100011) return "store";
    if (op == 7'b0110011) return "rtype";
    if (op == 7'b0010011) return "itype";
    if (op == 7'b1100011) return "branch";
    if (op == 7'b1101111 && JalEn) return "jal";
    return "illegal";
  endfunction

  function automatic ctl_t step_exp(input string s, input logic rdy, input logic z,
                                    input logic [6:0] op, input logic [2:0] f3,
                                    input logic f7);
    ctl_t e;
    e = '0;
    if (s == "fetch") begin
      e.mem_req = 1'b1; e.alu_src_b = 2'b10; e.result_src = 2'b10;
      e.ir_write = rdy; e.pc_write = rdy;
    end else if (s == "decode") begin
      e.alu_src_a = 2'b01; e.alu_src_b = 2'b01;
      e.imm_src = (op_class(op) == "jal") ? 2'b11 : 2'b10;
      e.illegal_instr = (op_class(op) == "illegal");
    end else if (s == "memadr") begin
      e.alu_src_a = 2'b10; e.alu_src_b = 2'b01;
      e.imm_src = (op_class(op) == "store") ? 2'b01 : 2'b00;
    end else if (s == "memread") begin
      e.mem_req = 1'b1; e.adr_src = 1'b1;
    end else if (s == "memwb") begin
      e.result_src = 2'b01; e.reg_write = 1'b1;
    end else if (s == "memwrite") begin
      e.mem_req = 1'b1; e.mem_write = 1'b1; e.adr_src = 1'b1;
    end else if (s == "execr") begin
      e.alu_src_a = 2'b10; e.alu_control = alu_ref(f3, 1'b1, f7);
    end else if (s == "execi") begin
      e.alu_src_a = 2'b10; e.alu_src_b = 2'b01; e.alu_control = alu_ref(f3, 1'b0, f7);
    end else if (s == "aluwb") begin
      e.reg_write = 1'b1;
    end else if (s == "branch") begin
      e.alu_src_a = 2'b10; e.alu_control = 3'b001;
      e.pc_write = (f3 == 3'b000) ? z : (f3 == 3'b001) ? ~z : 1'b0;
    end else if (s == "jal") begin
      e.alu_src_a = 2'b01; e.alu_src_b = 2'b10; e.pc_write = 1'b1;
    end
    return e;
  endfunction

  // Cycle sequence of one instruction with memory always ready.
  task automatic plan(input logic [6:0] op);
    string c;
    c = op_class(op);
    steps.delete();
    steps.push_back("fetch");
    steps.push_back("decode");
    if (c == "load") begin
      steps.push_back("memadr"); steps.push_back("memread"); steps.push_back("memwb");
    end else if (c == "store") begin
      steps.push_back("memadr"); steps.push_back("memwrite");
    end else if (c == "rtype") begin
      steps.push_back("execr"); steps.push_back("aluwb");
    end else if (c == "itype") begin
      steps.push_back("execi"); steps.push_back("aluwb");
    end else if (c == "branch") begin
      steps.push_back("branch");
    end else if (c == "jal") begin
      steps.push_back("jal"); steps.push_back("aluwb");
    end
  endtask

  // ---------------- stimulus ----------------
  task automatic apply(input string nm, input ctl_t e, input logic rdy, input logic z,
                       input logic [6:0] op, input logic [2:0] f3, input logic f7);
    @(posedge clk);
    #1;
    mem_if.mem_ready = rdy;
    zero = z;
    opcode = op;
    funct3 = f3;
    funct7b5 = f7;
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      mem_if.mem_ready = 1'b1;
      zero = 1'($urandom);
      opcode = 7'($urandom);
      exp_q.push_back('0);
      name_q.push_back("reset");
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    exp_q.push_back('0);
    name_q.push_back("idle");
  endtask

  // stall < 0: random stalls; zmode < 0: random zero; abort_at < 0: no reset.
  task automatic run_instr(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                           input int stall, input int zmode, input int abort_at);
    string      s;
    bit         stallable;
    int         lows;
    logic       rdy, z, f7d;
    logic [6:0] opd;
    logic [2:0] f3d;
    plan(op);
    for (int i = 0; i < steps.size(); i++) begin
      s = steps[i];
      stallable = (s == "fetch" || s == "memread" || s == "memwrite");
      if (i == abort_at) begin
        if (stallable) begin
          apply(s, step_exp(s, 1'b0, 1'b0, op, f3, f7), 1'b0, 1'b0, op, f3, f7);
        end
        do_reset(1 + $urandom_range(0, 1));
        return;
      end
      lows = 0;
      if (stallable) begin
        if (stall >= 0) lows = stall;
        else if ($urandom_range(0, 3) == 0) lows = $urandom_range(1, 3);
      end
      for (int k = 0; k <= lows; k++) begin
        rdy = stallable ? (k == lows) : 1'($urandom);
        z = (zmode >= 0) ? 1'(zmode) : 1'($urandom);
        if (s == "fetch") begin
          opd = 7'($urandom); f3d = 3'($urandom); f7d = 1'($urandom);
        end else begin
          opd = op; f3d = f3; f7d = f7;
        end
        apply(s, step_exp(s, rdy, z, opd, f3d, f7d), rdy, z, opd, f3d, f7d);
      end
    end
  endtask

  logic [6:0] rop;
  logic [6:0] op_pool[7];

  initial begin
    mem_if.mem_ready = 1'b1;
    op_pool[0] = 7'b0000011; op_pool[1] = 7'b0100011; op_pool[2] = 7'b0110011;
    op_pool[3] = 7'b0010011; op_pool[4] = 7'b1100011; op_pool[5] = 7'b1101111;
    op_pool[6] = 7'b0000000;

    do_reset(3);
    run_instr(7'b0000011, 3'b010, 1'b0, 0, -1, -1);  // lw, no stall
    run_instr(7'b0100011, 3'b010, 1'b0, 3, -1, -1);  // sw, 3 stall cycles per access
    run_instr(7'b1100011, 3'b000, 1'b0, 0, 1, -1);   // beq taken
    run_instr(7'b1100011, 3'b000, 1'b0, 0, 0, -1);   // beq not taken
    run_instr(7'b1100011, 3'b001, 1'b0, 0, 0, -1);   // bne taken
    run_instr(7'b1100011, 3'b100, 1'b0, 0, 1, -1);   // unsupported branch funct3
    run_instr(7'b0110011, 3'b000, 1'b1, 0, -1, -1);  // sub
    run_instr(7'b0010011, 3'b000, 1'b1, 0, -1, -1);  // addi, funct7b5 ignored
    run_instr(7'b1101111, 3'b000, 1'b0, 0, -1, -1);  // jal or illegal
    run_instr(7'b1111111, 3'b000, 1'b0, 0, -1, -1);  // illegal
    run_instr(7'b0000011, 3'b010, 1'b0, 2, -1, 3);   // reset during stalled load read

    for (int n = 0; n < 250; n++) begin
      rop = op_pool[$urandom_range(0, 6)];
      if (rop == 7'b0000000) rop = 7'($urandom);
      run_instr(rop, 3'($urandom), 1'($urandom), -1, -1,
                ($urandom_range(0, 7) == 0) ? $urandom_range(0, 4) : -1);
    end

    for (int t = 0; t < 10 && exp_q.size() > 0; t++) @(negedge clk);
    #1;
    if (exp_q.size() > 0) begin
      miscompares++;
      $display("FAIL drain pending=%0d want=0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mc_control_fsm.md
# mc_control_fsm

Multi-cycle control sequencer for the RV32I subset core (lw, sw, R-type, I-type ALU, beq/bne). It walks each instruction through fetch, decode, execute, memory and writeback. Each cycle it drives the shared-datapath selects: immediate format (imm_src), ALU operand muxes, ALU operation and write enables. A ready handshake stalls it on unified instruction/data memory.

## Interface
- No parameters; all encodings are fixed.
- clk  in  1  core clock; all state changes on the rising edge
- rst_n  in  1  asynchronous active-low reset
- opcode  in  7  instr[6:0] from the instruction register
- funct3  in  3  instr[14:12]
- funct7b5  in  1  instr[30]
- zero  in  1  ALU zero flag
- mem_ready  in  1  memory has completed the current access this cycle
- mem_req  out  1  memory access active
- mem_write  out  1  access is a store
- adr_src  out  1  0 = PC, 1 = ALU result register
- ir_write  out  1  load the instruction register and the old-PC register
- pc_write  out  1  PC enable (unconditional OR taken branch)
- reg_write  out  1  register file write enable
- imm_src  out  2  00 = I, 01 = S, 10 = B, 11 = J
- alu_src_a  out  2  00 = PC, 01 = old PC, 10 = rs1 data
- alu_src_b  out  2  00 = rs2 data, 01 = immediate, 10 = constant 4
- alu_control  out  3  000 add, 001 sub, 010 and, 011 or, 101 slt
- result_src  out  2  00 = ALU-out register, 01 = data-memory register, 10 = live ALU result
- illegal_instr  out  1  one-cycle pulse on an unsupported opcode

## Operation
- States: IDLE, FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB, BRANCH, plus JAL when configured.
- IDLE:
  - All outputs 0.
  - Always goes to FETCH on the next edge.
- FETCH:
  - mem_req=1, adr_src=0, alu_src_a=00, alu_src_b=10, add, result_src=10.
  - When mem_ready=1: ir_write=1, pc_write=1, go to DECODE. Otherwise hold with both strobes 0.
- DECODE:
  - alu_src_a=01, alu_src_b=01, imm_src=10, add. This precomputes the branch target into the ALU-out register.
  - Dispatch on opcode:
    - 0000011 or 0100011 → MEMADR
    - 0110011 → EXECR
    - 0010011 → EXECI
    - 1100011 → BRANCH
    - anything else → FETCH with illegal_instr=1
- MEMADR:
  - alu_src_a=10, alu_src_b=01, add.
  - imm_src=00 for loads, 01 for stores.
  - Loads go to MEMREAD; stores go to MEMWRITE.
- MEMREAD: mem_req=1, adr_src=1. Wait for mem_ready, then MEMWB.
- MEMWB: result_src=01, reg_write=1, then FETCH.
- MEMWRITE: mem_req=1, mem_write=1, adr_src=1. Wait for mem_ready, then FETCH.
- EXECR: alu_src_a=10, alu_src_b=00, then ALUWB.
- EXECI: alu_src_a=10, alu_src_b=01, imm_src=00, then ALUWB.
- ALUWB: result_src=00, reg_write=1, then FETCH.
- ALU decode in EXECR and EXECI, by funct3:
  - 000: sub only when R-type and funct7b5=1; add otherwise.
  - 010: slt. 110: or. 111: and.
  - Any other funct3: add (unsupported, no flag).
- BRANCH:
  - alu_src_a=10, alu_src_b=00, sub, result_src=00.
  - pc_write = zero for funct3=000, !zero for 001, 0 otherwise.
  - Then FETCH.
- Moore outputs come from the state register, except pc_write in BRANCH/FETCH and ir_write, which are qualified by zero and mem_ready.

## Timing
- rst_n low forces IDLE at once (asynchronous); all outputs 0 while held. Deassertion is sampled at a rising edge.
- Reset mid-instruction: no writes complete and the instruction restarts from IDLE. A partially stalled access is abandoned; mem_req drops in the same cycle.
- Cycle counts with mem_ready held 1:
  - lw 5, sw 4, R-type 4, I-type 4, branch 3, jal 4.
  - Illegal opcode: 2, then FETCH.
- Each cycle mem_ready is low in FETCH, MEMREAD or MEMWRITE adds exactly one cycle. All outputs stay stable through the stall.
- mem_ready outside those three states is ignored.
- illegal_instr pulses in the DECODE cycle only.

## Configuration
- MC_CTRL_JAL_EN defined: opcode 1101111 dispatches from DECODE to JAL.
  - JAL drives alu_src_a=01, alu_src_b=10, add, result_src=00, pc_write=1. The PC is loaded with the target precomputed in DECODE, which uses imm_src=11 for this opcode.
  - Then ALUWB writes the link value (old PC + 4).
- Not defined: the JAL state is absent, 1101111 is illegal, and imm_src never takes 11.

## Test plan
- rst_n low for 3 cycles with mem_ready=1 → all outputs 0; first cycle after release is IDLE, second is FETCH with mem_req=1, ir_write=1, pc_write=1.
- lw (opcode 0000011), mem_ready=1 → states FETCH, DECODE, MEMADR, MEMREAD, MEMWB; reg_write=1 with result_src=01 only in cycle 5; imm_src=00 in MEMADR.
- sw with mem_ready low for 3 cycles in MEMWRITE → mem_write=1 held 4 cycles, then FETCH; no reg_write at any point; imm_src=01 in MEMADR.
- beq, funct3=000, zero=1 → pc_write=1 in BRANCH. The same with zero=0 → pc_write=0. bne with zero=0 → pc_write=1.
- R-type funct3=000, funct7b5=1 → alu_control=001 in EXECR. I-type with the same bits → 000.
- opcode 1101111 → with MC_CTRL_JAL_EN: FETCH, DECODE (imm_src=11), JAL (pc_write=1), ALUWB (reg_write=1). Without it: illegal_instr=1 for one cycle, then FETCH.
